// File: rtl/parking_slot_controller.sv
// Parking slot controller: the upstream stage of the parking display.
// - Synchronises and debounces four slot occupancy sensors.
// - Runs the entry-gate FSM. Each admitted car holds a one-slot reservation.
// - Publishes registered capacity, first_empty and status flags.
//
// Ports:
//   clk_500Hz    system clock; all state changes on its rising edge
//   reset        synchronous, active-high reset
//   slot_sensor  raw, bouncy, asynchronous occupancy sensors (bit i = slot i)
//   entry_req    car waiting at the entry (level)
//   car_passed   one-cycle pulse when the car clears the gate
//   capacity     free, unreserved slots (0-4)
//   first_empty  lowest-index free slot (0 when all slots are occupied)
//   full         capacity == 0, aligned with capacity
//   gate_open    entry barrier open command
//   entry_denied one-cycle pulse when a request is refused because the lot is full
module parking_slot_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned GATE_TIMEOUT    = 2500,
  parameter int unsigned RESERVE_TIMEOUT = 15000
) (
  input  logic       clk_500Hz,
  input  logic       reset,
  input  logic [3:0] slot_sensor,
  input  logic       entry_req,
  input  logic       car_passed,
  output logic [2:0] capacity,
  output logic [1:0] first_empty,
  output logic       full,
  output logic       gate_open,
  output logic       entry_denied
);

  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned GateW = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;
  localparam int unsigned ResW  = (RESERVE_TIMEOUT > 1) ? $clog2(RESERVE_TIMEOUT) : 1;

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_TIMEOUT - 1);
  localparam logic [ResW-1:0]  ResLast  = ResW'(RESERVE_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StOpen, StReserved} state_e;

  logic [3:0]     sync1_q, sync2_q;
  logic [3:0]     occ_q, occ_d, occ_rise;
  logic [DbW-1:0] db_cnt_q [4];
  logic [DbW-1:0] db_cnt_d [4];

  logic [2:0] free_cnt, capacity_d, capacity_q;
  logic [1:0] first_empty_d, first_empty_q;
  logic       full_q;

  state_e           state_q;
  logic             reserved_q, gate_open_q, entry_denied_q, req_prev_q;
  logic [GateW-1:0] gate_tmr_q;
  logic [ResW-1:0]  res_tmr_q;

  // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    occ_d = occ_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != occ_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          occ_d[i] = ~occ_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rise seen on the same edge occupied updates, so the reservation is released on that edge.
  // Free count and reserved therefore drop together and capacity never dips by a phantom slot.
  assign occ_rise = occ_d & ~occ_q;

  always_comb begin
    free_cnt      = '0;
    first_empty_d = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!occ_q[i]) begin
        free_cnt = free_cnt + 3'd1;
      end
    end
    for (int i = 3; i >= 0; i--) begin
      if (!occ_q[i]) begin
        first_empty_d = 2'(i);
      end
    end
    capacity_d = (free_cnt > {2'b00, reserved_q}) ? (free_cnt - {2'b00, reserved_q}) : 3'd0;
  end

  always_ff @(posedge clk_500Hz) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      occ_q         <= '0;
      capacity_q    <= 3'd4;
      first_empty_q <= 2'd0;
      full_q        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= slot_sensor;
      sync2_q       <= sync1_q;
      occ_q         <= occ_d;
      capacity_q    <= capacity_d;
      first_empty_q <= first_empty_d;
      full_q        <= (capacity_d == 3'd0);
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Entry gate FSM. Timers count up from 0 and expire on their last count.
  always_ff @(posedge clk_500Hz) begin
    if (reset) begin
      state_q        <= StIdle;
      reserved_q     <= 1'b0;
      gate_open_q    <= 1'b0;
      entry_denied_q <= 1'b0;
      req_prev_q     <= 1'b0;
      gate_tmr_q     <= '0;
      res_tmr_q      <= '0;
    end else begin
      entry_denied_q <= 1'b0;
      req_prev_q     <= entry_req;
      case (state_q)
        StIdle: begin
          if (entry_req) begin
            if (capacity_q != 3'd0) begin
              state_q     <= StOpen;
              gate_open_q <= 1'b1;
              reserved_q  <= 1'b1;
              gate_tmr_q  <= '0;
            end else if (!req_prev_q) begin
              // Only a fresh request edge earns a denial pulse.
              entry_denied_q <= 1'b1;
            end
          end
        end
        StOpen: begin
          // car_passed takes priority over a coincident timeout.
          if (car_passed) begin
            state_q     <= StReserved;
            gate_open_q <= 1'b0;
            res_tmr_q   <= '0;
          end else if (gate_tmr_q == GateLast) begin
            state_q     <= StIdle;
            gate_open_q <= 1'b0;
            reserved_q  <= 1'b0;
          end else begin
            gate_tmr_q <= gate_tmr_q + 1'b1;
          end
        end
        StReserved: begin
          if ((|occ_rise) || (res_tmr_q == ResLast)) begin
            state_q    <= StIdle;
            reserved_q <= 1'b0;
          end else begin
            res_tmr_q <= res_tmr_q + 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          reserved_q  <= 1'b0;
          gate_open_q <= 1'b0;
        end
      endcase
    end
  end

  assign capacity     = capacity_q;
  assign first_empty  = first_empty_q;
  assign full         = full_q;
  assign gate_open    = gate_open_q;
  assign entry_denied = entry_denied_q;

endmodule

// File: tb/tb_parking_slot_controller.sv
module tb_parking_slot_controller;

  localparam int unsigned D = 4;
  localparam int unsigned G = 20;
  localparam int unsigned R = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] slot_sensor;
  logic       entry_req;
  logic       car_passed;
  logic [2:0] capacity;
  logic [1:0] first_empty;
  logic       full;
  logic       gate_open;
  logic       entry_denied;

  int n_chk  = 0;
  int n_fail = 0;

  parking_slot_controller #(
    .DEBOUNCE_CYCLES (D),
    .GATE_TIMEOUT    (G),
    .RESERVE_TIMEOUT (R)
  ) dut (
    .clk_500Hz    (clk),
    .reset        (reset),
    .slot_sensor  (slot_sensor),
    .entry_req    (entry_req),
    .car_passed   (car_passed),
    .capacity     (capacity),
    .first_empty  (first_empty),
    .full         (full),
    .gate_open    (gate_open),
    .entry_denied (entry_denied)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sensors;
    int         cap;
    int         fe;
    int         fl;
  } vec_t;

  vec_t vecs [9];

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int cap, input int fe, input int fl,
                         input int go);
    chk({tag, " capacity"}, int'(capacity), cap);
    chk({tag, " first_empty"}, int'(first_empty), fe);
    chk({tag, " full"}, int'(full), fl);
    chk({tag, " gate_open"}, int'(gate_open), go);
  endtask

  initial begin
    int pulses;

    vecs[0] = '{4'b0000, 4, 0, 0};
    vecs[1] = '{4'b0001, 3, 1, 0};
    vecs[2] = '{4'b0011, 2, 2, 0};
    vecs[3] = '{4'b0101, 2, 1, 0};
    vecs[4] = '{4'b0111, 1, 3, 0};
    vecs[5] = '{4'b1111, 0, 0, 1};
    vecs[6] = '{4'b1110, 1, 0, 0};
    vecs[7] = '{4'b1000, 3, 0, 0};
    vecs[8] = '{4'b1011, 1, 2, 0};

    reset       = 1'b1;
    slot_sensor = 4'b0000;
    entry_req   = 1'b0;
    car_passed  = 1'b0;

    // Reset state.
    tick(3);
    chk_out("in_reset", 4, 0, 0, 0);
    chk("in_reset entry_denied", int'(entry_denied), 0);
    reset = 1'b0;
    tick(1);
    chk_out("after_reset", 4, 0, 0, 0);

    // Short glitches on slot 1 must never be accepted.
    for (int k = 0; k < 4; k++) begin
      slot_sensor = 4'b0010;
      tick(1);
      chk("bounce hi capacity", int'(capacity), 4);
      slot_sensor = 4'b0000;
      tick(1);
      chk("bounce lo capacity", int'(capacity), 4);
      tick(1);
      chk("bounce lo2 capacity", int'(capacity), 4);
    end
    // Stable hold: occupied sets at edge 2+D, capacity follows one edge later.
    slot_sensor = 4'b0010;
    for (int k = 1; k <= 2 + D; k++) begin
      tick(1);
      chk("hold pre capacity", int'(capacity), 4);
    end
    tick(1);
    chk_out("hold done", 3, 0, 0, 0);

    // Steady-state occupancy patterns.
    for (int i = 0; i < 9; i++) begin
      slot_sensor = vecs[i].sensors;
      tick(12);
      chk_out($sformatf("vec%0d", i), vecs[i].cap, vecs[i].fe, vecs[i].fl, 0);
    end

    // Admit, pass, then the reserved slot fills.
    slot_sensor = 4'b0011;
    tick(12);
    chk_out("adm idle", 2, 2, 0, 0);
    entry_req = 1'b1;
    tick(1);
    chk_out("adm open", 2, 2, 0, 1);
    entry_req = 1'b0;
    tick(1);
    chk_out("adm reserved", 1, 2, 0, 1);
    car_passed = 1'b1;
    tick(1);
    car_passed = 1'b0;
    chk_out("adm passed", 1, 2, 0, 0);
    entry_req = 1'b1;
    tick(3);
    chk("rsv ignores req gate_open", int'(gate_open), 0);
    entry_req   = 1'b0;
    slot_sensor = 4'b0111;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk("fill capacity", int'(capacity), 1);
    end
    chk_out("fill done", 1, 3, 0, 0);

    // Gate timeout without car_passed.
    entry_req = 1'b1;
    tick(1);
    chk("gto open", int'(gate_open), 1);
    entry_req = 1'b0;
    tick(1);
    chk_out("gto reserved", 0, 3, 1, 1);
    tick(G - 2);
    chk("gto last open cycle", int'(gate_open), 1);
    tick(1);
    chk_out("gto closed", 0, 3, 1, 0);
    tick(1);
    chk_out("gto released", 1, 3, 0, 0);

    // car_passed on the timeout edge wins; reservation then expires after R cycles.
    entry_req = 1'b1;
    tick(1);
    entry_req = 1'b0;
    tick(G - 1);
    chk("tie still open", int'(gate_open), 1);
    car_passed = 1'b1;
    tick(1);
    car_passed = 1'b0;
    chk("tie gate_open", int'(gate_open), 0);
    tick(1);
    chk_out("tie kept reservation", 0, 3, 1, 0);
    tick(R - 2);
    chk("rto last reserved capacity", int'(capacity), 0);
    tick(1);
    chk("rto edge capacity", int'(capacity), 0);
    tick(1);
    chk_out("rto released", 1, 3, 0, 0);

    // Unrelated car fills a slot while the gate is open: capacity saturates at 0.
    entry_req = 1'b1;
    tick(1);
    entry_req   = 1'b0;
    slot_sensor = 4'b1111;
    tick(10);
    chk_out("open fill", 0, 0, 1, 1);
    car_passed = 1'b1;
    tick(1);
    car_passed = 1'b0;
    tick(R + 2);
    chk_out("full idle", 0, 0, 1, 0);

    // Denial: one pulse per request edge, gate stays closed.
    entry_req = 1'b1;
    pulses    = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (k == 0) chk("deny first cycle", int'(entry_denied), 1);
      if (entry_denied) pulses++;
      chk("deny gate_open", int'(gate_open), 0);
    end
    chk("deny pulse count", pulses, 1);
    entry_req = 1'b0;
    tick(2);
    entry_req = 1'b1;
    pulses    = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (entry_denied) pulses++;
    end
    chk("redeny pulse count", pulses, 1);
    entry_req = 1'b0;

    // Reset mid-OPEN aborts the gate and reservation.
    slot_sensor = 4'b0011;
    tick(12);
    chk("rst pre capacity", int'(capacity), 2);
    entry_req = 1'b1;
    tick(1);
    entry_req = 1'b0;
    tick(1);
    chk_out("rst open", 1, 2, 0, 1);
    reset = 1'b1;
    tick(1);
    chk_out("rst applied", 4, 0, 0, 0);
    reset = 1'b0;
    tick(1);
    chk_out("rst released", 4, 0, 0, 0);
    entry_req = 1'b1;
    tick(1);
    chk("rst idle readmit gate_open", int'(gate_open), 1);
    entry_req = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
